// File: rtl/mem_access_if.sv
// mem_access_if: single-outstanding req/ack data bus between the memory-access
// stage and the data memory / bus slave.
//   dbus_req    request, held high from issue until ack (or abort)
//   dbus_we     1 = write
//   dbus_addr   word-aligned address (bits [1:0] always 0)
//   dbus_sel    byte-lane enables, little-endian (bit n = bits [8n+7:8n])
//   dbus_wdata  lane-replicated store data
//   dbus_ack    one-cycle completion strobe from the slave
//   dbus_rdata  read data, valid with dbus_ack
// Modports: master (pipeline side), slave (memory side).
interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              dbus_req;
  logic              dbus_we;
  logic [ADDR_W-1:0] dbus_addr;
  logic [3:0]        dbus_sel;
  logic [31:0]       dbus_wdata;
  logic              dbus_ack;
  logic [31:0]       dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage between ex_mem and mem_wb.
// ALU results and HI/LO writes pass straight through; loads and stores run on
// a single-outstanding req/ack bus while the earlier stages are stalled.
// Performs byte/halfword lane selection, load extension and alignment checks.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   ex_*              instruction fields from ex_mem
//   wdata/waddr/wr_en register write to mem_wb
//   mem_hi/mem_lo/mem_hilo_en  HI/LO write to mem_wb
//   dbus              data bus (mem_access_if.master)
//   stall_req         freeze ex_mem and earlier stages
//   misalign          alignment exception flag (combinational)
//   bus_err           bus timeout abort flag (one DONE cycle)
//
// Optional feature: define MEM_TIMEOUT_EN to abort a bus access that has not
// been acknowledged after TIMEOUT_CYCLES BUSY cycles.
module mem_access #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_waddr,
  input  logic              ex_wr_en,
  input  logic [31:0]       ex_hi,
  input  logic [31:0]       ex_lo,
  input  logic              ex_hilo_en,
  input  logic [3:0]        ex_mem_op,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [31:0]       ex_mem_sdata,
  output logic [31:0]       wdata,
  output logic [4:0]        waddr,
  output logic              wr_en,
  output logic [31:0]       mem_hi,
  output logic [31:0]       mem_lo,
  output logic              mem_hilo_en,
  mem_access_if.master      dbus,
  output logic              stall_req,
  output logic              misalign,
  output logic              bus_err
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mem_access: TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic [31:0] rdata_p1;
  logic [3:0]  op_p1;
  logic [1:0]  lane_p1;
  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        misal_c, issue;
  logic [3:0]  sel_c;
  logic [31:0] swdata_c;

  // Lane pick and extension of the captured read word for the load in DONE.
  function automatic logic [31:0] load_extend(input logic [3:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   load_extend = 32'(b);
      OP_LBU:  load_extend = {24'd0, b};
      OP_LH:   load_extend = 32'(h);
      OP_LHU:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Decode of the incoming instruction.
  always_comb begin
    is_byte  = (ex_mem_op == OP_LB) || (ex_mem_op == OP_LBU) || (ex_mem_op == OP_SB);
    is_half  = (ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH);
    is_word  = (ex_mem_op == OP_LW) || (ex_mem_op == OP_SW);
    is_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
    is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
    misal_c  = (is_half && ex_mem_addr[0]) || (is_word && (ex_mem_addr[1:0] != 2'b00));
    issue    = (state == S_IDLE) && (is_load || is_store) && !misal_c;
    sel_c    = 4'b1111;
    swdata_c = ex_mem_sdata;
    if (is_byte) begin
      sel_c    = 4'b0001 << ex_mem_addr[1:0];
      swdata_c = {4{ex_mem_sdata[7:0]}};
    end else if (is_half) begin
      sel_c    = ex_mem_addr[1] ? 4'b1100 : 4'b0011;
      swdata_c = {2{ex_mem_sdata[15:0]}};
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_p1;
  assign bus_err = err_p1;
`else
  assign bus_err = 1'b0;
`endif

  // p0 -> p1: bus control FSM; request and lanes are registered at issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      dbus.dbus_req <= 1'b0;
      dbus.dbus_we  <= 1'b0;
      dbus.dbus_sel <= 4'b0000;
      rdata_p1      <= '0;
      op_p1         <= OP_NONE;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt       <= '0;
      err_p1        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            dbus.dbus_req <= 1'b1;
            dbus.dbus_we  <= is_store;
            dbus.dbus_sel <= sel_c;
            op_p1         <= ex_mem_op;
            state         <= S_BUSY;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        S_BUSY: begin
          // An ack in the same cycle as the timeout takes priority.
          if (dbus.dbus_ack) begin
            dbus.dbus_req <= 1'b0;
            rdata_p1      <= dbus.dbus_rdata;
            state         <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            dbus.dbus_req <= 1'b0;
            rdata_p1      <= '0;
            err_p1        <= 1'b1;
            state         <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
          err_p1 <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // p0 -> p1: address, store data and lane offset (data path, no reset).
  always_ff @(posedge clk) begin
    if (issue) begin
      dbus.dbus_addr  <= {ex_mem_addr[ADDR_W-1:2], 2'b00};
      dbus.dbus_wdata <= swdata_c;
      lane_p1         <= ex_mem_addr[1:0];
    end
  end

  // p1 output: pass-through, load result in DONE, all forced low in reset.
  always_comb begin
    wdata       = ex_wdata;
    waddr       = ex_waddr;
    wr_en       = ex_wr_en;
    mem_hi      = ex_hi;
    mem_lo      = ex_lo;
    mem_hilo_en = ex_hilo_en;
    misalign    = misal_c;
    stall_req   = issue || (state == S_BUSY);
    if (state == S_DONE) begin
      wdata = load_extend(op_p1, lane_p1, rdata_p1);
      if ((op_p1 >= OP_SB) || bus_err) wr_en = 1'b0;
    end
    if (misal_c) wr_en = 1'b0;
    if (!rst) begin
      wdata       = '0;
      waddr       = '0;
      wr_en       = 1'b0;
      mem_hi      = '0;
      mem_lo      = '0;
      mem_hilo_en = 1'b0;
      misalign    = 1'b0;
      stall_req   = 1'b0;
    end
  end

endmodule
